pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and
// MEM-stage wait handling with timeout into a sticky error state.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W  = 4,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_uses_src2,
  input  logic                  id_ex_mem_read,
  input  logic                  id_ex_wb_en,
  input  logic [REG_ADDR_W-1:0] id_ex_dest,
  input  logic                  branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_freeze,
  output logic                  if_id_freeze,
  output logic                  id_ex_freeze,
  output logic                  ex_mem_freeze,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  mem_wb_flush,
  output logic [1:0]            state,
  output logic                  mem_err,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } state_t;

  state_t            st_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              mem_block;
  logic              any_freeze;
  logic              br_flush;

  // Hazard detection; register 0 is treated like any other register.
  assign load_use = id_ex_mem_read & id_ex_wb_en &
                    ((id_ex_dest == id_src1) |
                     (id_uses_src2 & (id_ex_dest == id_src2)));
  // A dropped mem_req counts as completion, so it never blocks.
  assign mem_block = mem_req & ~mem_ready;

  assign state      = st_q;
  assign any_freeze = pc_freeze | if_id_freeze | id_ex_freeze | ex_mem_freeze;

  // Zero-latency freeze/flush decode from current state and inputs.
  always_comb begin
    pc_freeze     = 1'b0;
    if_id_freeze  = 1'b0;
    id_ex_freeze  = 1'b0;
    ex_mem_freeze = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_flush  = 1'b0;
    br_flush      = 1'b0;
    if (!rst) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else begin
      case (st_q)
        RUN, MEM_WAIT: begin
          if (mem_block) begin
            pc_freeze     = 1'b1;
            if_id_freeze  = 1'b1;
            id_ex_freeze  = 1'b1;
            ex_mem_freeze = 1'b1;
            mem_wb_flush  = 1'b1;
          end else if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            br_flush    = 1'b1;
          end else if (load_use) begin
            pc_freeze    = 1'b1;
            if_id_freeze = 1'b1;
            id_ex_flush  = 1'b1;
          end
        end
        MEM_ERR: begin
          pc_freeze     = 1'b1;
          if_id_freeze  = 1'b1;
          id_ex_freeze  = 1'b1;
          ex_mem_freeze = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // State machine and memory-wait timer; MEM_ERR is left only via reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q     <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (st_q)
        RUN: begin
          if (mem_block) begin
            st_q     <= MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (!mem_block) begin
            st_q     <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
            st_q    <= MEM_ERR;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        MEM_ERR: st_q <= MEM_ERR;
        default: begin
          st_q     <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (any_freeze && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (br_flush && (flush_count != '1)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a default instance plus a
// CNT_W=4 instance sharing the same stimulus for saturation checks.
module tb_pipe_hazard_ctrl;

  // freeze/flush patterns: {pc,if_id,id_ex,ex_mem freeze, if_id,id_ex,mem_wb flush}
  localparam logic [6:0] P_NONE = 7'b0000_000;
  localparam logic [6:0] P_MEMB = 7'b1111_001;
  localparam logic [6:0] P_BR   = 7'b0000_110;
  localparam logic [6:0] P_LU   = 7'b1100_010;
  localparam logic [6:0] P_ERR  = 7'b1111_000;
  localparam logic [6:0] P_RST  = 7'b0000_111;

  typedef struct packed {
    logic       rst;
    logic       req;
    logic       rdy;
    logic       br;
    logic [2:0] lu;
    logic [6:0] c;
    logic [1:0] st;
    logic       err;
    logic       cbr;
    logic       clr;
  } row_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_src1, id_src2, id_ex_dest;
  logic       id_uses_src2, id_ex_mem_read, id_ex_wb_en;
  logic       branch_taken, mem_req, mem_ready;

  logic        a_pcf, a_ifidf, a_idexf, a_exmemf, a_ifidfl, a_idexfl, a_memwbfl;
  logic [1:0]  a_state;
  logic        a_err;
  logic [15:0] a_stall, a_flush;
  logic        b_pcf, b_ifidf, b_idexf, b_exmemf, b_ifidfl, b_idexfl, b_memwbfl;
  logic [1:0]  b_state;
  logic        b_err;
  logic [3:0]  b_stall, b_flush;

  int total = 0;
  int bad   = 0;
  int es, ef, es4, ef4;
  logic [49:0] sb[$];
  wire  [49:0] obs_w = {a_pcf, a_ifidf, a_idexf, a_exmemf, a_ifidfl, a_idexfl, a_memwbfl,
                        a_state, a_err, a_stall, a_flush, b_stall, b_flush};

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
    .id_uses_src2(id_uses_src2), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_wb_en(id_ex_wb_en), .id_ex_dest(id_ex_dest),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_freeze(a_pcf), .if_id_freeze(a_ifidf), .id_ex_freeze(a_idexf),
    .ex_mem_freeze(a_exmemf), .if_id_flush(a_ifidfl), .id_ex_flush(a_idexfl),
    .mem_wb_flush(a_memwbfl), .state(a_state), .mem_err(a_err),
    .stall_count(a_stall), .flush_count(a_flush)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
    .id_uses_src2(id_uses_src2), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_wb_en(id_ex_wb_en), .id_ex_dest(id_ex_dest),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_freeze(b_pcf), .if_id_freeze(b_ifidf), .id_ex_freeze(b_idexf),
    .ex_mem_freeze(b_exmemf), .if_id_flush(b_ifidfl), .id_ex_flush(b_idexfl),
    .mem_wb_flush(b_memwbfl), .state(b_state), .mem_err(b_err),
    .stall_count(b_stall), .flush_count(b_flush)
  );

  always #5 clk = ~clk;

  function automatic row_t R(input logic r, input logic q, input logic y, input logic b,
                             input logic [2:0] lu, input logic [6:0] c, input logic [1:0] st,
                             input logic err, input logic cbr, input logic clr);
    row_t x;
    x = {r, q, y, b, lu, c, st, err, cbr, clr};
    return x;
  endfunction

  // Drive one cycle of inputs and push the expected observation.
  // lu: 0 none, 1 src1 hit, 2 src2 hit, 3 src2 match unused, 4 no wb,
  //     5 reg0 hit, 6 not a load
  task automatic apply(input row_t r);
    rst = r.rst; mem_req = r.req; mem_ready = r.rdy; branch_taken = r.br;
    id_ex_mem_read = 1'b0; id_ex_wb_en = 1'b0; id_uses_src2 = 1'b0;
    id_ex_dest = 4'd3; id_src1 = 4'd5; id_src2 = 4'd6;
    case (r.lu)
      3'd1: begin id_ex_mem_read = 1; id_ex_wb_en = 1; id_src1 = 4'd3; end
      3'd2: begin id_ex_mem_read = 1; id_ex_wb_en = 1; id_uses_src2 = 1; id_src2 = 4'd3; end
      3'd3: begin id_ex_mem_read = 1; id_ex_wb_en = 1; id_src2 = 4'd3; end
      3'd4: begin id_ex_mem_read = 1; id_src1 = 4'd3; end
      3'd5: begin id_ex_mem_read = 1; id_ex_wb_en = 1; id_ex_dest = 4'd0; id_src1 = 4'd0; end
      3'd6: begin id_ex_wb_en = 1; id_src1 = 4'd3; end
      default: ;
    endcase
    sb.push_back({r.c, r.st, r.err, 16'(es), 16'(ef), 4'(es4), 4'(ef4)});
    if (r.c[6:3] != 4'd0) begin es++; if (es4 < 15) es4++; end
    if (r.cbr) begin ef++; if (ef4 < 15) ef4++; end
    if (r.clr) begin es = 0; ef = 0; es4 = 0; ef4 = 0; end
  endtask

  task automatic do_reset();
    apply(R(0, 0, 0, 0, 0, P_RST, 0, 0, 0, 1));
    void'(sb.pop_front());
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    row_t rows[$];
    logic [49:0] e;
    do_reset();
    rows.push_back(R(0, 1, 0, 1, 1, P_RST, 0, 0, 0, 1));
    rows.push_back(R(0, 0, 0, 0, 1, P_RST, 0, 0, 0, 1));
    rows.push_back(R(1, 0, 0, 0, 0, P_NONE, 0, 0, 0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (obs_w !== e) begin bad++; $display("FAIL reset step %0d: got=%h exp=%h", i, obs_w, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    row_t rows[$];
    logic [49:0] e;
    do_reset();
    rows.push_back(R(1, 0, 0, 0, 1, P_LU, 0, 0, 0, 0));
    rows.push_back(R(1, 0, 0, 0, 0, P_NONE, 0, 0, 0, 0));
    rows.push_back(R(1, 0, 0, 0, 2, P_LU, 0, 0, 0, 0));
    rows.push_back(R(1, 0, 0, 0, 3, P_NONE, 0, 0, 0, 0));
    rows.push_back(R(1, 0, 0, 0, 4, P_NONE, 0, 0, 0, 0));
    rows.push_back(R(1, 0, 0, 0, 6, P_NONE, 0, 0, 0, 0));
    rows.push_back(R(1, 0, 0, 0, 5, P_LU, 0, 0, 0, 0));
    rows.push_back(R(1, 1, 1, 0, 1, P_LU, 0, 0, 0, 0));
    rows.push_back(R(1, 0, 0, 0, 0, P_NONE, 0, 0, 0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (obs_w !== e) begin bad++; $display("FAIL load_use step %0d: got=%h exp=%h", i, obs_w, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    row_t rows[$];
    logic [49:0] e;
    do_reset();
    rows.push_back(R(1, 0, 0, 1, 1, P_BR, 0, 0, 1, 0));
    rows.push_back(R(1, 0, 0, 0, 0, P_NONE, 0, 0, 0, 0));
    rows.push_back(R(1, 0, 0, 1, 0, P_BR, 0, 0, 1, 0));
    rows.push_back(R(1, 0, 0, 1, 0, P_BR, 0, 0, 1, 0));
    rows.push_back(R(1, 1, 0, 1, 1, P_MEMB, 0, 0, 0, 0));
    rows.push_back(R(1, 0, 1, 0, 0, P_NONE, 1, 0, 0, 0));
    rows.push_back(R(1, 0, 0, 0, 0, P_NONE, 0, 0, 0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (obs_w !== e) begin bad++; $display("FAIL branch step %0d: got=%h exp=%h", i, obs_w, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_wait();
    row_t rows[$];
    logic [49:0] e;
    do_reset();
    rows.push_back(R(1, 1, 0, 0, 0, P_MEMB, 0, 0, 0, 0));
    rows.push_back(R(1, 1, 0, 0, 0, P_MEMB, 1, 0, 0, 0));
    rows.push_back(R(1, 1, 0, 0, 0, P_MEMB, 1, 0, 0, 0));
    rows.push_back(R(1, 1, 1, 0, 0, P_NONE, 1, 0, 0, 0));
    rows.push_back(R(1, 0, 0, 0, 0, P_NONE, 0, 0, 0, 0));
    rows.push_back(R(1, 1, 0, 0, 1, P_MEMB, 0, 0, 0, 0));
    rows.push_back(R(1, 1, 1, 0, 1, P_LU, 1, 0, 0, 0));
    rows.push_back(R(1, 0, 0, 0, 0, P_NONE, 0, 0, 0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (obs_w !== e) begin bad++; $display("FAIL mem_wait step %0d: got=%h exp=%h", i, obs_w, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wait_branch();
    row_t rows[$];
    logic [49:0] e;
    do_reset();
    rows.push_back(R(1, 1, 0, 1, 0, P_MEMB, 0, 0, 0, 0));
    rows.push_back(R(1, 1, 0, 1, 0, P_MEMB, 1, 0, 0, 0));
    rows.push_back(R(1, 0, 0, 1, 0, P_BR, 1, 0, 1, 0));
    rows.push_back(R(1, 0, 0, 0, 0, P_NONE, 0, 0, 0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (obs_w !== e) begin bad++; $display("FAIL wait_branch step %0d: got=%h exp=%h", i, obs_w, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    row_t rows[$];
    logic [49:0] e;
    do_reset();
    rows.push_back(R(1, 1, 0, 0, 0, P_MEMB, 0, 0, 0, 0));
    for (int k = 1; k <= 16; k++) rows.push_back(R(1, 1, 0, 0, 0, P_MEMB, 1, 0, 0, 0));
    for (int k = 17; k < 20; k++) rows.push_back(R(1, 1, 0, 0, 0, P_ERR, 2, 1, 0, 0));
    rows.push_back(R(1, 1, 1, 0, 0, P_ERR, 2, 1, 0, 0));
    rows.push_back(R(1, 0, 0, 1, 1, P_ERR, 2, 1, 0, 0));
    rows.push_back(R(0, 1, 0, 0, 0, P_RST, 2, 1, 0, 1));
    rows.push_back(R(1, 0, 0, 0, 0, P_NONE, 0, 0, 0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (obs_w !== e) begin bad++; $display("FAIL timeout step %0d: got=%h exp=%h", i, obs_w, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midwait();
    row_t rows[$];
    logic [49:0] e;
    do_reset();
    rows.push_back(R(1, 1, 0, 0, 0, P_MEMB, 0, 0, 0, 0));
    rows.push_back(R(1, 1, 0, 0, 0, P_MEMB, 1, 0, 0, 0));
    rows.push_back(R(0, 1, 0, 1, 1, P_RST, 1, 0, 0, 1));
    rows.push_back(R(1, 0, 0, 0, 0, P_NONE, 0, 0, 0, 0));
    rows.push_back(R(1, 1, 1, 1, 0, P_BR, 0, 0, 1, 0));
    rows.push_back(R(1, 0, 0, 0, 0, P_NONE, 0, 0, 0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (obs_w !== e) begin bad++; $display("FAIL reset_midwait step %0d: got=%h exp=%h", i, obs_w, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation();
    row_t rows[$];
    logic [49:0] e;
    do_reset();
    for (int k = 0; k < 20; k++) rows.push_back(R(1, 0, 0, 0, 1, P_LU, 0, 0, 0, 0));
    for (int k = 0; k < 20; k++) rows.push_back(R(1, 0, 0, 1, 0, P_BR, 0, 0, 1, 0));
    rows.push_back(R(1, 0, 0, 0, 0, P_NONE, 0, 0, 0, 0));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = sb.pop_front(); total++;
      if (obs_w !== e) begin bad++; $display("FAIL saturation step %0d: got=%h exp=%h", i, obs_w, e); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    es = 0; ef = 0; es4 = 0; ef4 = 0;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_wait_branch();
    test_timeout();
    test_reset_midwait();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
